// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory interface.
package lc3_pkg;

    localparam int unsigned LC3_WORD_W    = 16;
    localparam int unsigned LC3_MEM_TMO_W = 8;

    // Access FSM; encoding is fixed so the state can be probed by other blocks.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } lc3_mem_state_e;

endpackage

// File: rtl/lc3_mem_if_if.sv
// External memory port of the LC-3 memory interface.
// master: the lc3_mem_if block; slave: the memory model or controller.
interface lc3_mem_bus_if;
    import lc3_pkg::*;

    logic [LC3_WORD_W-1:0] mem_addr;
    logic [LC3_WORD_W-1:0] mem_wdata;
    logic [LC3_WORD_W-1:0] mem_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic                  mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/lc3_mem_timer.sv
// Watchdog counter for a pending memory access. Counts cycles while i_run is
// high and flags the cycle on which the access has waited LIMIT cycles.
module lc3_mem_timer
    import lc3_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam logic [LC3_MEM_TMO_W-1:0] LastCnt = LC3_MEM_TMO_W'(LIMIT - 1);

    logic [LC3_MEM_TMO_W-1:0] r_cnt;

    // Cycle counter; the FSM leaves the wait state on expiry so it never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_run && (r_cnt == LastCnt);

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 memory interface: MAR/MDR, memory handshake and gated MDR bus drive.
// Optional watchdog enabled by defining LC3_MEM_TIMEOUT_EN.
module lc3_mem_if
    import lc3_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [LC3_WORD_W-1:0] i_data_bus,
    input  logic                  i_ld_mar,
    input  logic                  i_ld_mdr,
    input  logic                  i_mio_en,
    input  logic                  i_r_w,
    input  logic                  i_gate_mdr,
    output logic [LC3_WORD_W-1:0] o_mdr_bus,
    output logic                  o_r,
    output logic                  o_mem_err,
    lc3_mem_bus_if.master         io_mem
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("lc3_mem_if: TIMEOUT_CYCLES must be in 1..255");
    end

    lc3_mem_state_e        r_state, w_state_d;
    logic [LC3_WORD_W-1:0] r_mar, w_mar_d;
    logic [LC3_WORD_W-1:0] r_mdr, w_mdr_d;
    logic                  r_req, w_req_d;
    logic                  r_we, w_we_d;
    logic                  r_err, w_err_d;
    logic                  w_in_wait;
    logic                  w_expired;

    assign w_in_wait = (r_state == RD_WAIT) || (r_state == WR_WAIT);

`ifdef LC3_MEM_TIMEOUT_EN
    lc3_mem_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (!w_in_wait),
        .i_run     (w_in_wait),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_mar   <= w_mar_d;
            r_mdr   <= w_mdr_d;
            r_req   <= w_req_d;
            r_we    <= w_we_d;
            r_err   <= w_err_d;
        end
    end

    // Next-state: loads only in IDLE, completion or abort in the wait states.
    always_comb begin
        w_state_d = r_state;
        w_mar_d   = r_mar;
        w_mdr_d   = r_mdr;
        w_req_d   = r_req;
        w_we_d    = r_we;
        w_err_d   = r_err;
        case (r_state)
            IDLE: begin
                if (i_ld_mar) begin
                    w_mar_d = i_data_bus;
                end
                if (i_ld_mdr && !i_mio_en) begin
                    w_mdr_d = i_data_bus;
                end
                if (i_mio_en) begin
                    w_we_d    = i_r_w;
                    w_req_d   = 1'b1;
                    w_state_d = i_r_w ? WR_WAIT : RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                // A ready on the expiry cycle is a normal completion.
                if (io_mem.mem_ready) begin
                    w_req_d   = 1'b0;
                    w_state_d = DONE;
                    if (r_state == RD_WAIT) begin
                        w_mdr_d = io_mem.mem_rdata;
                    end
                end else if (w_expired) begin
                    w_req_d   = 1'b0;
                    w_err_d   = 1'b1;
                    w_state_d = DONE;
                    if (r_state == RD_WAIT) begin
                        w_mdr_d = '0;
                    end
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign io_mem.mem_addr  = r_mar;
    assign io_mem.mem_wdata = r_mdr;
    assign io_mem.mem_req   = r_req;
    assign io_mem.mem_we    = r_we;
    assign o_r              = (r_state == DONE);
    assign o_mem_err        = r_err;
    assign o_mdr_bus        = i_gate_mdr ? r_mdr : '0;

endmodule
